// File: rtl/bcd_display_scanner_pkg.sv
// Shared definitions for the 4-digit BCD display scanner.
// Holds the 7-segment pattern type and the segment constants (gfedcba,
// active-high), the slot count, and the slot-index state type.
package bcd_display_pkg;

  localparam int NUM_SLOTS = 4;

  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_e;

  localparam seg_t SEG_0    = 7'b0111111;
  localparam seg_t SEG_1    = 7'b0000110;
  localparam seg_t SEG_2    = 7'b1011011;
  localparam seg_t SEG_3    = 7'b1001111;
  localparam seg_t SEG_4    = 7'b1100110;
  localparam seg_t SEG_5    = 7'b1101101;
  localparam seg_t SEG_6    = 7'b1111101;
  localparam seg_t SEG_7    = 7'b0000111;
  localparam seg_t SEG_8    = 7'b1111111;
  localparam seg_t SEG_9    = 7'b1101111;
  localparam seg_t SEG_DASH = 7'b1000000;
  localparam seg_t SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Signal bundle between a BCD digit source and the display scanner.
//   digits   : {d3,d2,d1,d0} BCD digits, d0 least significant
//   blank_lz : leading-zero blanking enable
//   dp_mask  : decimal point enable per slot
//   seg      : segment bus {g,f,e,d,c,b,a}
//   dp       : decimal point segment
//   an       : one-hot digit select
//   frame    : one-cycle pulse after each snapshot load
// master = the digit source side, slave = the scanner.
interface bcd_display_scanner_if;
  import bcd_display_pkg::*;

  logic [15:0] digits;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  seg_t        seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  modport master (
    output digits, blank_lz, dp_mask,
    input  seg, dp, an, frame
  );

  modport slave (
    input  digits, blank_lz, dp_mask,
    output seg, dp, an, frame
  );

endinterface

// File: rtl/bcd_display_scanner_bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder (gfedcba, active-high).
//   bcd : 4-bit input code
//   seg : segment pattern; codes 10..15 show a dash
module bcd_to_7seg
  import bcd_display_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 4-digit 7-segment scanner.
// Each slot lasts REFRESH_DIV cycles: one blank anti-ghost cycle followed
// by REFRESH_DIV-1 lit cycles. The digits, blanking enable and dp mask are
// snapshotted once per frame so a frame never mixes old and new values.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of bcd_display_scanner_if
module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int REFRESH_DIV    = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_display_scanner_if.slave  bus
);

  localparam int P_W = $clog2(REFRESH_DIV);
  localparam logic [P_W-1:0] P_LAST = P_W'(REFRESH_DIV - 1);

  logic [P_W-1:0] p_q, p_d;
  slot_e          idx_q, idx_d;
  logic           frame_start;

  logic [15:0]    snap_digits;
  logic           snap_blank_lz;
  logic [3:0]     snap_dp_mask;

  logic [3:0]     cur_digit;
  seg_t           dec_seg;
  logic [3:0]     zero;
  logic [3:0]     lz_blank;
  logic           slot_blank;

  seg_t           seg_n;
  logic [3:0]     an_n;
  logic           dp_n;

  // Slot sequencing: prescaler and slot index
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q   <= '0;
      idx_q <= SLOT0;
    end else begin
      p_q   <= p_d;
      idx_q <= idx_d;
    end
  end

  always_comb begin
    p_d   = p_q + P_W'(1);
    idx_d = idx_q;
    if (p_q == P_LAST) begin
      p_d   = '0;
      idx_d = slot_e'(idx_q + 2'd1);
    end
  end

  assign frame_start = (p_q == '0) && (idx_q == SLOT0);

  // Frame snapshot
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_digits   <= '0;
      snap_blank_lz <= 1'b0;
      snap_dp_mask  <= '0;
    end else if (frame_start) begin
      snap_digits   <= bus.digits;
      snap_blank_lz <= bus.blank_lz;
      snap_dp_mask  <= bus.dp_mask;
    end
  end

  assign cur_digit = snap_digits[{idx_q, 2'b00} +: 4];

  bcd_to_7seg u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // A slot is a leading zero when it and every higher digit are zero;
  // invalid codes are non-zero, so they stop the blanking run.
  always_comb begin
    for (int j = 0; j < NUM_SLOTS; j++) begin
      zero[j] = (snap_digits[4*j +: 4] == 4'd0);
    end
    lz_blank[0] = 1'b0;
    lz_blank[1] = zero[3] & zero[2] & zero[1];
    lz_blank[2] = zero[3] & zero[2];
    lz_blank[3] = zero[3];
  end

  assign slot_blank = snap_blank_lz & lz_blank[idx_q];

  always_comb begin
    seg_n = SEG_OFF;
    an_n  = 4'b0000;
    dp_n  = 1'b0;
    if (p_q != '0) begin
      an_n  = 4'b0001 << idx_q;
      seg_n = slot_blank ? SEG_OFF : dec_seg;
      dp_n  = snap_dp_mask[idx_q];
    end
  end

  // Output registers, polarity applied on the final value only
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.seg   <= {7{SEG_ACTIVE_LOW}};
      bus.dp    <= SEG_ACTIVE_LOW;
      bus.an    <= {4{AN_ACTIVE_LOW}};
      bus.frame <= 1'b0;
    end else begin
      bus.seg   <= seg_n ^ {7{SEG_ACTIVE_LOW}};
      bus.dp    <= dp_n ^ SEG_ACTIVE_LOW;
      bus.an    <= an_n ^ {4{AN_ACTIVE_LOW}};
      bus.frame <= frame_start;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed testbench for bcd_display_scanner with REFRESH_DIV=4.
// dut_a is active-high, dut_b is fully active-low.
module tb_bcd_display_scanner;

  localparam int DIV = 4;
  localparam int LIT = DIV - 1;

  logic clk;
  logic reset_a;
  logic reset_b;
  int   n_checks;
  int   n_errors;

  bcd_display_scanner_if bus_a ();
  bcd_display_scanner_if bus_b ();

  bcd_display_scanner #(
    .REFRESH_DIV    (DIV),
    .SEG_ACTIVE_LOW (1'b0),
    .AN_ACTIVE_LOW  (1'b0)
  ) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a)
  );

  bcd_display_scanner #(
    .REFRESH_DIV    (DIV),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered just after the edge that starts slot i (gap cycle follows);
  // leaves just after the edge that starts the next slot.
  task automatic run_slot(input int i, input logic [6:0] s, input logic d);
    logic [3:0] exp_an;
    exp_an = 4'b0001 << i;
    check_eq($sformatf("gap%0d_an", i), {12'd0, bus_a.an}, 16'd0);
    check_eq($sformatf("gap%0d_seg", i), {9'd0, bus_a.seg}, 16'd0);
    check_eq($sformatf("gap%0d_dp", i), {15'd0, bus_a.dp}, 16'd0);
    check_eq($sformatf("gap%0d_frame", i), {15'd0, bus_a.frame}, (i == 0) ? 16'd1 : 16'd0);
    for (int k = 0; k < LIT; k++) begin
      tick();
      check_eq($sformatf("slot%0d_an", i), {12'd0, bus_a.an}, {12'd0, exp_an});
      check_eq($sformatf("slot%0d_seg", i), {9'd0, bus_a.seg}, {9'd0, s});
      check_eq($sformatf("slot%0d_dp", i), {15'd0, bus_a.dp}, {15'd0, d});
      check_eq($sformatf("slot%0d_frame", i), {15'd0, bus_a.frame}, 16'd0);
    end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_a = 1'b1;
    reset_b = 1'b1;
    bus_a.digits   = 16'h1234;
    bus_a.blank_lz = 1'b0;
    bus_a.dp_mask  = 4'b0000;
    bus_b.digits   = 16'h0008;
    bus_b.blank_lz = 1'b0;
    bus_b.dp_mask  = 4'b0000;

    tick();
    tick();
    check_eq("rst_an", {12'd0, bus_a.an}, 16'd0);
    check_eq("rst_seg", {9'd0, bus_a.seg}, 16'd0);
    check_eq("rst_dp", {15'd0, bus_a.dp}, 16'd0);
    check_eq("rst_frame", {15'd0, bus_a.frame}, 16'd0);
    check_eq("rstb_seg", {9'd0, bus_b.seg}, 16'h007f);
    check_eq("rstb_dp", {15'd0, bus_b.dp}, 16'd1);
    check_eq("rstb_an", {12'd0, bus_b.an}, 16'h000f);

    // Frame 1: 1234, digits switch to 5678 mid-frame without tearing
    reset_a = 1'b0;
    tick();
    run_slot(0, 7'b1100110, 1'b0);
    bus_a.digits = 16'h5678;
    run_slot(1, 7'b1001111, 1'b0);
    run_slot(2, 7'b1011011, 1'b0);
    run_slot(3, 7'b0000110, 1'b0);

    // Frame 2: 5678
    run_slot(0, 7'b1111111, 1'b0);
    run_slot(1, 7'b0000111, 1'b0);
    run_slot(2, 7'b1111101, 1'b0);
    bus_a.digits   = 16'h0050;
    bus_a.blank_lz = 1'b1;
    run_slot(3, 7'b1101101, 1'b0);

    // Frame 3: 0050 with leading-zero blanking
    run_slot(0, 7'b0111111, 1'b0);
    run_slot(1, 7'b1101101, 1'b0);
    run_slot(2, 7'b0000000, 1'b0);
    bus_a.digits  = 16'h0000;
    bus_a.dp_mask = 4'b0100;
    run_slot(3, 7'b0000000, 1'b0);

    // Frame 4: all zero, dp on slot 2 only
    run_slot(0, 7'b0111111, 1'b0);
    run_slot(1, 7'b0000000, 1'b0);
    run_slot(2, 7'b0000000, 1'b1);
    bus_a.digits  = 16'h00A0;
    bus_a.dp_mask = 4'b0000;
    run_slot(3, 7'b0000000, 1'b0);

    // Frame 5: invalid code in slot 1, then reset during slot 2
    run_slot(0, 7'b0111111, 1'b0);
    run_slot(1, 7'b1000000, 1'b0);
    check_eq("f5_gap2_an", {12'd0, bus_a.an}, 16'd0);
    tick();
    check_eq("f5_slot2_an", {12'd0, bus_a.an}, 16'h0004);
    check_eq("f5_slot2_seg", {9'd0, bus_a.seg}, 16'd0);
    reset_a = 1'b1;
    bus_a.digits   = 16'h4321;
    bus_a.blank_lz = 1'b0;
    tick();
    check_eq("midrst_an", {12'd0, bus_a.an}, 16'd0);
    check_eq("midrst_seg", {9'd0, bus_a.seg}, 16'd0);
    check_eq("midrst_dp", {15'd0, bus_a.dp}, 16'd0);
    check_eq("midrst_frame", {15'd0, bus_a.frame}, 16'd0);
    reset_a = 1'b0;
    tick();
    run_slot(0, 7'b0000110, 1'b0);
    run_slot(1, 7'b1011011, 1'b0);
    run_slot(2, 7'b1001111, 1'b0);
    run_slot(3, 7'b1100110, 1'b0);
    check_eq("f7_frame", {15'd0, bus_a.frame}, 16'd1);

    // Active-low instance: digit 8 in slot 0
    reset_b = 1'b0;
    tick();
    check_eq("b_gap_an", {12'd0, bus_b.an}, 16'h000f);
    check_eq("b_gap_seg", {9'd0, bus_b.seg}, 16'h007f);
    check_eq("b_frame", {15'd0, bus_b.frame}, 16'd1);
    tick();
    check_eq("b_slot0_seg", {9'd0, bus_b.seg}, 16'd0);
    check_eq("b_slot0_an", {12'd0, bus_b.an}, 16'h000e);
    check_eq("b_slot0_dp", {15'd0, bus_b.dp}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
